// File: rtl/rv_pkg.sv
// Shared RV decode definitions.
// Holds the major-opcode and funct7 constants, the functional-unit and
// immediate-format enums, the decoded-entry struct and the immediate builder.
package rv_pkg;

  // Major opcodes, instr[6:2]
  localparam logic [4:0] OPCODE_LOAD     = 5'b00000;
  localparam logic [4:0] OPCODE_MISCMEM  = 5'b00011;
  localparam logic [4:0] OPCODE_OPIMM    = 5'b00100;
  localparam logic [4:0] OPCODE_AUIPC    = 5'b00101;
  localparam logic [4:0] OPCODE_OPIMM32  = 5'b00110;
  localparam logic [4:0] OPCODE_STORE    = 5'b01000;
  localparam logic [4:0] OPCODE_OP       = 5'b01100;
  localparam logic [4:0] OPCODE_LUI      = 5'b01101;
  localparam logic [4:0] OPCODE_OP32     = 5'b01110;
  localparam logic [4:0] OPCODE_BRANCH   = 5'b11000;
  localparam logic [4:0] OPCODE_JALR     = 5'b11001;
  localparam logic [4:0] OPCODE_JAL      = 5'b11011;
  localparam logic [4:0] OPCODE_SYSTEM   = 5'b11100;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    UNIT_ALU    = 2'd0,
    UNIT_MUL    = 2'd1,
    UNIT_LSU    = 2'd2,
    UNIT_BRANCH = 2'd3
  } unit_t;

  // FMT_R means "no immediate" (imm = 0)
  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
  } imm_fmt_t;

  // imm is always built at 64 bits; narrower datapaths take the low XLEN bits.
  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    unit_t       unit;
    logic [3:0]  alu_op;
    logic        rd_we;
    logic        word;
    logic        illegal;
  } dec_t;

  function automatic logic [63:0] imm_gen(imm_fmt_t fmt, logic [31:0] i);
    case (fmt)
      FMT_I:   imm_gen = {{52{i[31]}}, i[31:20]};
      FMT_S:   imm_gen = {{52{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   imm_gen = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      FMT_U:   imm_gen = {{32{i[31]}}, i[31:12], 12'b0};
      FMT_J:   imm_gen = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm_gen = '0;
    endcase
  endfunction

endpackage

// File: rtl/rv_decoder.sv
// Combinational RV instruction decoder.
// Ports:
//   instr_i  raw 32-bit instruction
//   dec_o    decoded fields (registers, 64-bit sign-extended imm, unit,
//            alu_op, rd write enable, W-op flag, illegal flag)
module rv_decoder
  import rv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 0,
  parameter int ENABLE_W = 0
) (
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  localparam bit M_OK = (ENABLE_M != 0);
  localparam bit W_OK = (ENABLE_W != 0) && (XLEN == 64);

  logic [4:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  imm_fmt_t   fmt;
  unit_t      unit;
  logic [3:0] op;
  logic       we, word, ill, shift_imm;

  assign opc = instr_i[6:2];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];
  assign rd  = instr_i[11:7];

  always_comb begin
    fmt       = FMT_R;
    unit      = UNIT_ALU;
    op        = {1'b0, f3};
    we        = 1'b1;
    word      = 1'b0;
    ill       = 1'b0;
    shift_imm = 1'b0;
    case (opc)
      OPCODE_LOAD:    begin fmt = FMT_I; unit = UNIT_LSU; end
      OPCODE_STORE:   begin fmt = FMT_S; unit = UNIT_LSU; we = 1'b0; end
      OPCODE_MISCMEM: begin fmt = FMT_I; we = 1'b0; end
      OPCODE_SYSTEM:  fmt = FMT_I;
      OPCODE_LUI,
      OPCODE_AUIPC:   begin fmt = FMT_U; op = 4'd0; end
      OPCODE_JAL:     begin fmt = FMT_J; unit = UNIT_BRANCH; op = 4'd0; end
      OPCODE_JALR:    begin fmt = FMT_I; unit = UNIT_BRANCH; end
      OPCODE_BRANCH: begin
        fmt  = FMT_B;
        unit = UNIT_BRANCH;
        we   = 1'b0;
        if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
      end
      OPCODE_OPIMM, OPCODE_OPIMM32: begin
        fmt  = FMT_I;
        word = (opc == OPCODE_OPIMM32);
        if (word && !W_OK) begin
          ill  = 1'b1;
          word = 1'b0;
        end
        if (f3 == 3'b001 || f3 == 3'b101) begin
          shift_imm = 1'b1;
          if (f3 == 3'b101) op[3] = instr_i[30];
          // shamt[5] only exists for full-width shifts on a 64-bit datapath
          if (instr_i[25] && (XLEN == 32 || word)) ill = 1'b1;
        end
      end
      OPCODE_OP, OPCODE_OP32: begin
        word = (opc == OPCODE_OP32);
        if (word && !W_OK) begin
          ill  = 1'b1;
          word = 1'b0;
        end
        if (f7 == FUNCT7_MULDIV) begin
          if (M_OK) unit = UNIT_MUL;
          else      ill  = 1'b1;
        end else if (f7 == FUNCT7_ALT) begin
          if (f3 == 3'b000 || f3 == 3'b101) op[3] = 1'b1;
        end else if (f7 != FUNCT7_BASE) begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    if (instr_i[1:0] != 2'b11) ill = 1'b1;
    if (ill) unit = UNIT_ALU;
  end

  always_comb begin
    dec_o.rd      = (fmt == FMT_S || fmt == FMT_B) ? 5'd0 : rd;
    dec_o.rs1     = (fmt == FMT_U || fmt == FMT_J) ? 5'd0 : instr_i[19:15];
    dec_o.rs2     = (fmt == FMT_I || fmt == FMT_U || fmt == FMT_J) ? 5'd0 : instr_i[24:20];
    if (shift_imm)
      dec_o.imm   = (XLEN == 64 && !word) ? {58'd0, instr_i[25:20]} : {59'd0, instr_i[24:20]};
    else
      dec_o.imm   = imm_gen(fmt, instr_i);
    dec_o.unit    = unit;
    dec_o.alu_op  = op;
    dec_o.rd_we   = we && !ill && (rd != 5'd0);
    dec_o.word    = word;
    dec_o.illegal = ill;
  end

endmodule

// File: rtl/rv_decode_stage.sv
// RV decode pipeline stage: decodes on the input side, then holds results in a
// 2-entry skid buffer (main + skid) so in_ready can come straight from a flop.
// Ports:
//   clk, rst_n (async active-low), flush_i (drops both entries and the input)
//   in_valid/in_ready/in_instr/in_pc       fetch side handshake
//   out_valid/out_ready/out_*              execute side handshake + fields
module rv_decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 0,
  parameter int ENABLE_W = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [1:0]      out_unit,
  output logic [3:0]      out_alu_op,
  output logic            out_rd_we,
  output logic            out_word,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    dec_t            d;
  } ent_t;

  dec_t in_dec;
  ent_t in_ent, main_q, main_d, skid_q, skid_d;
  logic main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic accept, consume;

  rv_decoder #(.XLEN(XLEN), .ENABLE_M(ENABLE_M), .ENABLE_W(ENABLE_W)) u_dec (
    .instr_i (in_instr),
    .dec_o   (in_dec)
  );

  assign in_ent   = {in_pc, in_dec};
  assign in_ready = !skid_v_q;
  assign accept   = in_valid && in_ready;
  assign consume  = main_v_q && out_ready;

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || consume) begin
      // Main frees up: refill from skid first (in_ready is low then), else input.
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else begin
        main_v_d = accept;
        if (accept) main_d = in_ent;
      end
    end else if (accept) begin
      skid_d   = in_ent;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

  assign out_valid   = main_v_q;
  assign out_pc      = main_q.pc;
  assign out_rd      = main_q.d.rd;
  assign out_rs1     = main_q.d.rs1;
  assign out_rs2     = main_q.d.rs2;
  assign out_imm     = main_q.d.imm[XLEN-1:0];
  assign out_unit    = main_q.d.unit;
  assign out_alu_op  = main_q.d.alu_op;
  assign out_rd_we   = main_q.d.rd_we;
  assign out_word    = main_q.d.word;
  assign out_illegal = main_q.d.illegal;

  // Upper immediate bits are just sign copies on a 32-bit datapath.
  if (XLEN < 64) begin : g_imm_hi
    logic unused_imm_hi;
    assign unused_imm_hi = ^main_q.d.imm[63:XLEN];
  end

endmodule
